// File: rtl/exa_crosb_output_vc_credit_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exanet_crosb_pkg
// Brief    : Shared sizing helpers and per-VC ownership state encoding for
//            the crossbar output VC credit tracker.
// Revision : 1.0 - initial release
// ============================================================================
package exanet_crosb_pkg;

  // Total number of output VCs across all priority levels
  function automatic int unsigned calc_nvc(input int unsigned prio_n,
                                           input int unsigned vc_n);
    return prio_n * vc_n;
  endfunction

  // Width of a VC index; a single VC still needs a one-bit index port
  function automatic int unsigned calc_vcw(input int unsigned nvc);
    return (nvc > 1) ? $clog2(nvc) : 1;
  endfunction

  // Width of a credit counter that must hold 0..credits inclusive
  function automatic int unsigned calc_cw(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

  // Per-VC packet ownership states
  localparam logic [0:0] VC_IDLE = 1'b0;
  localparam logic [0:0] VC_BUSY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/exa_crosb_output_vc_credit_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : exa_crosb_output_vc_credit_tracker_if
// Brief    : Send/credit event bus and per-VC status bus between the crossbar
//            output stage and the output VC credit tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface exa_crosb_output_vc_credit_tracker_if
  import exanet_crosb_pkg::*;
#(
  parameter int unsigned prio_num = 2,
  parameter int unsigned vc_num   = 2,
  parameter int unsigned CREDITS  = 8
);
  localparam int unsigned NVC = calc_nvc(prio_num, vc_num);
  localparam int unsigned VCW = calc_vcw(NVC);
  localparam int unsigned CW  = calc_cw(CREDITS);

  // Events from the crossbar output and the downstream receiver
  logic           i_send;
  logic [VCW-1:0] i_send_vc;
  logic           i_send_hdr;
  logic           i_send_tail;
  logic           i_credit_valid;
  logic [VCW-1:0] i_credit_vc;

  // Status towards the crossbar arbiter and VC allocator
  logic [NVC-1:0] o_vc_ready;
  logic [NVC-1:0] o_vc_avail;
  logic [CW-1:0]  o_vc_credits [NVC-1:0];
  logic           o_err_underflow;
  logic           o_err_overflow;

  // Event source side
  modport master (
    output i_send, i_send_vc, i_send_hdr, i_send_tail, i_credit_valid, i_credit_vc,
    input  o_vc_ready, o_vc_avail, o_vc_credits, o_err_underflow, o_err_overflow
  );

  // Tracker side
  modport slave (
    input  i_send, i_send_vc, i_send_hdr, i_send_tail, i_credit_valid, i_credit_vc,
    output o_vc_ready, o_vc_avail, o_vc_credits, o_err_underflow, o_err_overflow
  );

endinterface
`default_nettype wire

// File: rtl/exa_crosb_output_vc_credit_tracker_counter.sv
`default_nettype none
// ============================================================================
// Module   : exa_crosb_vc_credit_counter
// Brief    : One output VC: downstream credit counter with saturation,
//            IDLE/BUSY packet ownership FSM and single-cycle error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module exa_crosb_vc_credit_counter
  import exanet_crosb_pkg::*;
#(
  parameter int unsigned CREDITS = 8,
  parameter int unsigned CW      = calc_cw(CREDITS)
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  input  wire logic          send_i,
  input  wire logic          hdr_i,
  input  wire logic          tail_i,
  input  wire logic          credit_i,
  output logic [CW-1:0]      credits_o,
  output logic               busy_o,
  output logic               underflow_o,
  output logic               overflow_o
);

  localparam logic [CW-1:0] c_full = CW'(CREDITS);
  localparam logic [CW-1:0] c_one  = CW'(1);

  logic [CW-1:0] credits_q, credits_d;
  logic [0:0]    state_q, state_d;

  // Credit accounting: a same-cycle send and return cancel out, so neither
  // boundary check applies in that case
  always_comb begin
    credits_d   = credits_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    if (send_i && !credit_i) begin
      if (credits_q == '0) begin
        underflow_o = 1'b1;
      end else begin
        credits_d = credits_q - c_one;
      end
    end else if (credit_i && !send_i) begin
      if (credits_q == c_full) begin
        overflow_o = 1'b1;
      end else begin
        credits_d = credits_q + c_one;
      end
    end
  end

  // Ownership FSM: header claims the VC, tail releases it; a header seen while
  // already busy is tolerated and does not release ownership
  always_comb begin
    state_d = state_q;
    if (send_i) begin
      case (state_q)
        VC_IDLE: if (hdr_i && !tail_i) state_d = VC_BUSY;
        VC_BUSY: if (tail_i)           state_d = VC_IDLE;
        default:                       state_d = VC_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset to a full, idle VC
  always_ff @(posedge clk) begin
    if (!resetn) begin
      credits_q <= c_full;
      state_q   <= VC_IDLE;
    end else begin
      credits_q <= credits_d;
      state_q   <= state_d;
    end
  end

  assign credits_o = credits_q;
  assign busy_o    = (state_q == VC_BUSY);

endmodule
`default_nettype wire

// File: rtl/exa_crosb_output_vc_credit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : exa_crosb_output_vc_credit_tracker
// Brief    : Output-port credit and ownership tracker for all output VCs.
//            Decodes send/credit events per VC and exports ready/available
//            status plus sticky underflow/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module exa_crosb_output_vc_credit_tracker
  import exanet_crosb_pkg::*;
#(
  parameter int unsigned prio_num = 2,
  parameter int unsigned vc_num   = 2,
  parameter int unsigned CREDITS  = 8
) (
  input  wire logic                          clk,
  input  wire logic                          resetn,
  exa_crosb_output_vc_credit_tracker_if.slave bus
);

  localparam int unsigned NVC = calc_nvc(prio_num, vc_num);
  localparam int unsigned VCW = calc_vcw(NVC);
  localparam int unsigned CW  = calc_cw(CREDITS);

  logic [NVC-1:0] send_oh_w;
  logic [NVC-1:0] credit_oh_w;
  logic [NVC-1:0] busy_w;
  logic [NVC-1:0] under_w;
  logic [NVC-1:0] over_w;
  logic [CW-1:0]  credits_w [NVC-1:0];

  logic err_under_q, err_under_d;
  logic err_over_q,  err_over_d;

  // One-hot decode of event VCs; indices with no matching VC decode to nothing
  always_comb begin
    send_oh_w   = '0;
    credit_oh_w = '0;
    for (int v = 0; v < int'(NVC); v++) begin
      send_oh_w[v]   = bus.i_send         && (bus.i_send_vc   == VCW'(v));
      credit_oh_w[v] = bus.i_credit_valid && (bus.i_credit_vc == VCW'(v));
    end
  end

  generate
    for (genvar v = 0; v < int'(NVC); v++) begin : g_vc
      exa_crosb_vc_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
      ) u_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .send_i      (send_oh_w[v]),
        .hdr_i       (bus.i_send_hdr),
        .tail_i      (bus.i_send_tail),
        .credit_i    (credit_oh_w[v]),
        .credits_o   (credits_w[v]),
        .busy_o      (busy_w[v]),
        .underflow_o (under_w[v]),
        .overflow_o  (over_w[v])
      );

      assign bus.o_vc_credits[v] = credits_w[v];
      assign bus.o_vc_ready[v]   = (credits_w[v] != '0);
      assign bus.o_vc_avail[v]   = (credits_w[v] != '0) && !busy_w[v];
    end
  endgenerate

  // Error flags accumulate any per-VC pulse and hold until reset
  always_comb begin
    err_under_d = err_under_q | (|under_w);
    err_over_d  = err_over_q  | (|over_w);
  end

  // Sticky error registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
    end
  end

  assign bus.o_err_underflow = err_under_q;
  assign bus.o_err_overflow  = err_over_q;

endmodule
`default_nettype wire

// File: tb/tb_exa_crosb_output_vc_credit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_exa_crosb_output_vc_credit_tracker
// Brief    : Directed self-checking bench for the output VC credit tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exa_crosb_output_vc_credit_tracker;

  logic clk;
  logic resetn;

  int n_checks;
  int n_fail;

  exa_crosb_output_vc_credit_tracker_if #(
    .prio_num (2),
    .vc_num   (2),
    .CREDITS  (8)
  ) bus ();

  exa_crosb_output_vc_credit_tracker #(
    .prio_num (2),
    .vc_num   (2),
    .CREDITS  (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_send         = 1'b0;
    bus.i_send_vc      = '0;
    bus.i_send_hdr     = 1'b0;
    bus.i_send_tail    = 1'b0;
    bus.i_credit_valid = 1'b0;
    bus.i_credit_vc    = '0;
  endtask

  // Present one cycle of events, clock it in, and return 1 ns after the edge
  task automatic cycle(input logic snd, input int svc, input logic hdr, input logic tail,
                       input logic crd, input int cvc);
    bus.i_send         = snd;
    bus.i_send_vc      = 2'(svc);
    bus.i_send_hdr     = hdr;
    bus.i_send_tail    = tail;
    bus.i_credit_valid = crd;
    bus.i_credit_vc    = 2'(cvc);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_all_reset(input string tag);
    for (int v = 0; v < 4; v++) check({tag, "_credits"}, 32'(bus.o_vc_credits[v]), 32'd8);
    check({tag, "_ready"}, 32'(bus.o_vc_ready), 32'hF);
    check({tag, "_avail"}, 32'(bus.o_vc_avail), 32'hF);
    check({tag, "_under"}, 32'(bus.o_err_underflow), 32'd0);
    check({tag, "_over"},  32'(bus.o_err_overflow),  32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    check_all_reset("rst");

    // Multi-flit packet on VC2: hdr, body, body, tail
    cycle(1, 2, 1, 0, 0, 0);
    check("vc2_hdr_cred",  32'(bus.o_vc_credits[2]), 32'd7);
    check("vc2_hdr_avail", 32'(bus.o_vc_avail[2]),   32'd0);
    check("vc2_hdr_ready", 32'(bus.o_vc_ready[2]),   32'd1);
    cycle(1, 2, 0, 0, 0, 0);
    check("vc2_b1_cred",   32'(bus.o_vc_credits[2]), 32'd6);
    check("vc2_b1_avail",  32'(bus.o_vc_avail[2]),   32'd0);
    cycle(1, 2, 0, 0, 0, 0);
    check("vc2_b2_cred",   32'(bus.o_vc_credits[2]), 32'd5);
    check("vc2_b2_ready",  32'(bus.o_vc_ready[2]),   32'd1);
    cycle(1, 2, 0, 1, 0, 0);
    check("vc2_tail_cred", 32'(bus.o_vc_credits[2]), 32'd4);
    check("vc2_tail_avail", 32'(bus.o_vc_avail), 32'hF);

    // Eight single-flit packets on VC1 drain it
    for (int k = 0; k < 8; k++) cycle(1, 1, 1, 1, 0, 0);
    check("vc1_empty_cred",  32'(bus.o_vc_credits[1]), 32'd0);
    check("vc1_empty_ready", 32'(bus.o_vc_ready),      32'b1101);
    check("vc1_empty_avail", 32'(bus.o_vc_avail),      32'b1101);
    check("vc1_empty_under", 32'(bus.o_err_underflow), 32'd0);
    cycle(1, 1, 1, 1, 0, 0);
    check("vc1_uf_flag", 32'(bus.o_err_underflow), 32'd1);
    check("vc1_uf_cred", 32'(bus.o_vc_credits[1]), 32'd0);
    cycle(0, 0, 0, 0, 1, 1);
    check("vc1_ret_cred",  32'(bus.o_vc_credits[1]), 32'd1);
    check("vc1_ret_ready", 32'(bus.o_vc_ready[1]),   32'd1);
    // Drain again, then send+credit at zero must hold zero
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 1);
    check("vc1_zero_both", 32'(bus.o_vc_credits[1]), 32'd0);

    // Headerless flits on idle VC0 consume credits without claiming it
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0, 0);
    check("vc0_body_cred",  32'(bus.o_vc_credits[0]), 32'd3);
    check("vc0_body_avail", 32'(bus.o_vc_avail[0]),   32'd1);
    cycle(1, 0, 0, 0, 1, 0);
    check("vc0_both_cred", 32'(bus.o_vc_credits[0]), 32'd3);
    check("vc0_both_over", 32'(bus.o_err_overflow),  32'd0);
    cycle(1, 0, 0, 0, 1, 3);
    check("split_vc0_cred", 32'(bus.o_vc_credits[0]), 32'd2);
    check("split_vc3_cred", 32'(bus.o_vc_credits[3]), 32'd8);
    check("split_over",     32'(bus.o_err_overflow),  32'd1);
    check("split_under",    32'(bus.o_err_underflow), 32'd1);

    // VC3: header, repeated header (violation), body -> busy with 5 credits
    cycle(1, 3, 1, 0, 0, 0);
    cycle(1, 3, 1, 0, 0, 0);
    check("vc3_viol_avail", 32'(bus.o_vc_avail), 32'b0101);
    cycle(1, 3, 0, 0, 0, 0);
    check("vc3_busy_cred",  32'(bus.o_vc_credits[3]), 32'd5);
    check("vc3_busy_ready", 32'(bus.o_vc_ready),      32'b1101);
    check("vc3_busy_avail", 32'(bus.o_vc_avail[3]),   32'd0);

    // Mid-packet reset clears everything
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_all_reset("rst2");

    // Tail after a single header releases VC3 again
    cycle(1, 3, 1, 0, 0, 0);
    check("vc3_rehdr_avail", 32'(bus.o_vc_avail[3]), 32'd0);
    cycle(1, 3, 0, 1, 0, 0);
    check("vc3_tail_avail",  32'(bus.o_vc_avail[3]),   32'd1);
    check("vc3_tail_cred",   32'(bus.o_vc_credits[3]), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exa_crosb_output_vc_credit_tracker.md
Name: exa_crosb_output_vc_credit_tracker

Overview:
- Output-port companion to output VC allocation: sits between the crossbar output and the downstream link.
- Tracks downstream buffer credits and per-packet ownership for every output VC (vc_num*prio_num of them).
- Consumes flit-send events and credit returns from the downstream receiver; exports per-VC ready/available status used by the crossbar arbiter and VC allocator.

Parameters:
prio_num, 2, number of priority levels
vc_num, 2, VCs per priority; NVC = vc_num*prio_num, VCW = $clog2(NVC)
CREDITS, 8, downstream buffer depth per VC in flits (>=1); CW = $clog2(CREDITS+1)

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
i_send  input  1  one flit transmitted downstream this cycle
i_send_vc  input  VCW  output VC of sent flit
i_send_hdr  input  1  sent flit is first flit of packet
i_send_tail  input  1  sent flit is last flit of packet
i_credit_valid  input  1  downstream returns one credit this cycle
i_credit_vc  input  VCW  VC of returned credit
o_vc_ready  output  NVC  bit v: credits[v] > 0 (flit may be sent on v)
o_vc_avail  output  NVC  bit v: !busy[v] && credits[v] > 0 (new packet may be allocated to v)
o_vc_credits  output  CW x NVC (unpacked array [NVC-1:0])  current credit count per VC
o_err_underflow  output  1  sticky: send on a VC with zero credits
o_err_overflow  output  1  sticky: credit return on a VC already at CREDITS

Behaviour:
- Reset (resetn low at posedge clk): credits[v]=CREDITS, busy[v]=0, both error flags 0. Hence o_vc_ready=all 1, o_vc_avail=all 1, o_vc_credits=CREDITS.
- Reset mid-packet discards all ownership and credit state; no pending state survives.
- All state is registered. Outputs are combinational from state only, never from inputs.
- Latency: an event sampled at edge t is visible on outputs after edge t (cycle t+1).
- Credit counter per VC, evaluated each edge:
  - send only on v: credits-1.
  - credit only on v: credits+1.
  - send and credit on same v in same cycle: unchanged, no error, even when count is 0 or CREDITS.
  - send on v1 and credit on v2 (v1 != v2): each counter updated independently.
- Underflow: i_send on v with credits[v]==0 and no same-cycle credit on v. Counter stays 0 (saturates); o_err_underflow set.
- Overflow: i_credit_valid on v with credits[v]==CREDITS and no same-cycle send on v. Counter stays CREDITS; o_err_overflow set.
- Error flags are cleared only by reset.
- Ownership per VC (2-state FSM per VC, IDLE/BUSY; busy = state==BUSY):
  - IDLE -> BUSY on send with hdr=1, tail=0.
  - hdr=1, tail=1 (single-flit packet): stays IDLE.
  - BUSY -> IDLE on send with tail=1.
  - BUSY, send with hdr=1: protocol violation. Stays BUSY; tail still releases.
  - Body flits (hdr=0, tail=0): no state change.
  - A flit without hdr in IDLE changes no ownership state; the credit is still consumed.
- Ownership updates are applied even when the send underflows.
- VC index >= NVC (non-power-of-2 NVC): event ignored, no state change.

Decomposition:
- exanet_crosb_pkg holds localparams/functions for NVC, VCW, CW and the per-VC state enum (VC_IDLE, VC_BUSY).
- Sub-module exa_crosb_vc_credit_counter: one VC's credit counter, ownership FSM and per-VC error pulses. Instantiated NVC times in a generate loop.
- Top level decodes VC indices to one-hot, distributes events, and ORs the error pulses into the sticky flags.
- Target total: about 150-250 lines of RTL.

Test Plan:
- Reset release -> o_vc_credits all 8, o_vc_ready=4'hF, o_vc_avail=4'hF, both error flags 0.
- Send hdr on VC2, then 2 body flits, then tail (4 consecutive cycles):
  - o_vc_avail[2]=0 from cycle after hdr until cycle after tail.
  - o_vc_credits[2] steps 7,6,5,4.
  - o_vc_ready[2] stays 1 throughout.
- Send 8 single-flit packets on VC1, then one more flit:
  - o_vc_credits[1]=0, o_vc_ready[1]=0 after 8th send.
  - 9th send sets o_err_underflow=1 with count still 0.
  - One credit return then gives count 1.
- At credits[0]=3: send and credit on VC0 in same cycle -> stays 3, no error. Same-cycle send VC0 + credit VC3 (VC3 at 8) -> VC0=2, VC3 stays 8, o_err_overflow=1.
- Reset asserted while VC3 BUSY with credits 5 -> after reset VC3 credits=8, o_vc_avail[3]=1, error flags cleared.
